// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM types, constants and helpers
package pwm_pkg;

   // Default measurement width for the capture block
   localparam int PWM_CNT_W_DEFAULT = 16;

   // Capture operating mode, driven straight from the mode input bit
   typedef enum logic {
      PWM_CAP_CONTINUOUS = 1'b0,
      PWM_CAP_ONESHOT    = 1'b1
   } pwm_cap_mode_t;

   // Capture FSM states
   typedef enum logic [1:0] {
      CAP_IDLE      = 2'd0,
      CAP_WAIT_RISE = 2'd1,
      CAP_HIGH      = 2'd2,
      CAP_LOW       = 2'd3
   } pwm_cap_state_t;

   // Every state other than IDLE is part of an active measurement
   function automatic logic cap_is_busy(input pwm_cap_state_t s);
      return (s != CAP_IDLE);
   endfunction

   // A measurement is running and its counters advance
   function automatic logic cap_is_measuring(input pwm_cap_state_t s);
      return (s == CAP_HIGH) || (s == CAP_LOW);
   endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - pwm_in synchroniser, edge detector and post-reset edge suppression
module pwm_in_sync
   import pwm_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   // Suppression lasts SYNC_STAGES+1 cycles: long enough for a level that was
   // already present at reset release to ripple through chain and compare flop.
   localparam int                SUPP_W      = $clog2(SYNC_STAGES + 2);
   localparam logic [SUPP_W-1:0] SUPP_CYCLES = SUPP_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [SUPP_W-1:0]      r_supp_cnt;
   logic                   w_last;
   logic                   w_armed;

   assign w_last  = r_sync[SYNC_STAGES-1];
   assign w_armed = (r_supp_cnt == SUPP_CYCLES);

   // Synchroniser chain followed by the compare flop
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
         r_prev <= w_last;
      end
   end

   // Count out the suppression window after reset, then hold
   always_ff @(posedge clk) begin
      if (reset) begin
         r_supp_cnt <= '0;
      end else if (!w_armed) begin
         r_supp_cnt <= r_supp_cnt + 1'b1;
      end
   end

   // Edge strobes are qualified by the suppression window
   always_comb begin
      level = w_last;
      rise  = w_armed &  w_last & ~r_prev;
      fall  = w_armed & ~w_last &  r_prev;
   end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture: measures period and high time in prescaled ticks
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = PWM_CNT_W_DEFAULT,
   parameter int SYNC_STAGES = 2
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             arm,
   input  logic [15:0]      prescaler,
   input  logic             clear_overflow,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             capture_valid,
   output logic             busy,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] MEAS_MAX = '1;

   pwm_cap_state_t   r_state;
   pwm_cap_state_t   w_state_next;
   pwm_cap_mode_t    w_mode;

   logic [15:0]      r_presc_lat;
   logic [15:0]      r_presc_cnt;
   logic [CNT_W-1:0] r_meas_cnt;
   logic [CNT_W-1:0] r_high_shadow;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high_time;
   logic             r_valid;
   logic             r_overflow;

   logic             w_level;
   logic             w_rise_raw;
   logic             w_fall_raw;
   logic             w_rise;
   logic             w_fall;
   logic             w_tick;
   logic [CNT_W-1:0] w_meas_inc;
   logic             w_sat;

   logic             w_busy;
   logic             w_restart;
   logic             w_shadow_ld;
   logic             w_capture;
   logic             w_ovf_set;

   pwm_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .level  (w_level),
      .rise   (w_rise_raw),
      .fall   (w_fall_raw)
   );

   assign w_mode = pwm_cap_mode_t'(mode);

   // Edge strobes cross-checked against the synchronised level they came from
   assign w_rise = w_rise_raw &  w_level;
   assign w_fall = w_fall_raw & ~w_level;

   // The count presented at an edge includes the tick that completes on the
   // edge cycle itself, so E elapsed cycles report floor(E/(prescaler+1)).
   assign w_tick     = (r_presc_cnt == r_presc_lat);
   assign w_meas_inc = r_meas_cnt + {{(CNT_W-1){1'b0}}, w_tick};
   assign w_sat      = (r_meas_cnt == MEAS_MAX);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= CAP_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state decision; disable always wins, saturation beats an edge
   always_comb begin
      w_state_next = r_state;
      if (!en) begin
         w_state_next = CAP_IDLE;
      end else begin
         case (r_state)
            CAP_IDLE: begin
               if ((w_mode == PWM_CAP_CONTINUOUS) || arm) begin
                  w_state_next = CAP_WAIT_RISE;
               end
            end
            CAP_WAIT_RISE: begin
               if (w_rise) begin
                  w_state_next = CAP_HIGH;
               end
            end
            CAP_HIGH: begin
               if (w_sat) begin
                  w_state_next = CAP_WAIT_RISE;
               end else if (w_fall) begin
                  w_state_next = CAP_LOW;
               end
            end
            CAP_LOW: begin
               if (w_sat) begin
                  w_state_next = CAP_WAIT_RISE;
               end else if (w_rise) begin
                  w_state_next = (w_mode == PWM_CAP_CONTINUOUS) ? CAP_HIGH : CAP_IDLE;
               end
            end
            default: w_state_next = CAP_IDLE;
         endcase
      end
   end

   // FSM outputs: status and datapath strobes for the current state
   always_comb begin
      w_busy      = cap_is_busy(r_state);
      w_restart   = 1'b0;
      w_shadow_ld = 1'b0;
      w_capture   = 1'b0;
      w_ovf_set   = 1'b0;
      if (en) begin
         case (r_state)
            CAP_WAIT_RISE: begin
               w_restart = w_rise;
            end
            CAP_HIGH: begin
               w_ovf_set   = w_sat;
               w_shadow_ld = !w_sat && w_fall;
            end
            CAP_LOW: begin
               w_ovf_set = w_sat;
               w_capture = !w_sat && w_rise;
               w_restart = !w_sat && w_rise && (w_mode == PWM_CAP_CONTINUOUS);
            end
            default: begin
            end
         endcase
      end
   end

   // Prescale and measure counters; a rise restarts them aligned to the edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc_lat <= '0;
         r_presc_cnt <= '0;
         r_meas_cnt  <= '0;
      end else if (w_restart) begin
         r_presc_lat <= prescaler;
         r_presc_cnt <= '0;
         r_meas_cnt  <= '0;
      end else if (cap_is_measuring(r_state)) begin
         if (w_tick) begin
            r_presc_cnt <= '0;
            r_meas_cnt  <= w_meas_inc;
         end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
         end
      end
   end

   // High-time shadow and published results with their one-cycle valid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_high_shadow <= '0;
         r_period      <= '0;
         r_high_time   <= '0;
         r_valid       <= 1'b0;
      end else begin
         r_valid <= w_capture;
         if (w_shadow_ld) begin
            r_high_shadow <= w_meas_inc;
         end
         if (w_capture) begin
            r_period    <= w_meas_inc;
            r_high_time <= r_high_shadow;
         end
      end
   end

   // Sticky overflow; a new saturation outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_ovf_set) begin
         r_overflow <= 1'b1;
      end else if (clear_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign period        = r_period;
   assign high_time     = r_high_time;
   assign capture_valid = r_valid;
   assign busy          = w_busy;
   assign overflow      = r_overflow;

endmodule
